// File: rtl/sdram_arb_pkg.sv
// Shared FSM state type, direction constants and flattened-vector field slicer
// for the N-channel SDRAM burst arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_UPD
    } arb_state_t;

    localparam logic DIR_WR = 1'b1;
    localparam logic DIR_RD = 1'b0;

    // Widest flattened channel vector the slicer accepts (8 channels x 31 bits fits).
    localparam int FLAT_W = 256;

    function automatic logic [31:0] ch_field(input logic [FLAT_W-1:0] vec,
                                             input int idx,
                                             input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return 32'(vec >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/sdram_ch_addr_gen.sv
// Per-channel burst address: window wrap, deferred reload, frame-done pulse in the update cycle.
// Optional bank bit (SDRAM_PINGPONG_EN) prepended as the address MSB.
module sdram_ch_addr_gen
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = 22,
    parameter int LEN_W  = 9
) (
    input  logic              clk_ref,
    input  logic              rst,
    input  logic              load,
    input  logic              pick,
    input  logic              granted,
    input  logic              upd,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] max_addr,
`ifdef SDRAM_PINGPONG_EN
    input  logic              dir,
    input  logic              wr_bank_done,
    output logic              done_bank,
`endif
    output logic [ADDR_W-1:0] eff_addr,
    output logic              frame_done
);

    logic [ADDR_W-1:0] addr;
    logic              pend;
    logic [ADDR_W:0]   next;
    logic [ADDR_W+1:0] next_end;
    logic              wrap;
    logic [ADDR_W-1:0] base;

    assign next       = {1'b0, addr} + (ADDR_W+1)'(len);
    assign next_end   = {1'b0, next} + (ADDR_W+2)'(len);
    assign wrap       = next_end > (ADDR_W+2)'(max_addr);
    assign frame_done = upd && !pend && !load && wrap;
    // A pending or same-cycle reload must already be visible to the grant that latches it.
    assign base       = (pend || (load && !granted)) ? start_addr : addr;

`ifdef SDRAM_PINGPONG_EN
    logic bank;
    assign done_bank = bank;
    assign eff_addr  = {bank, base[ADDR_W-2:0]};
`else
    assign eff_addr  = base;
`endif

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            addr <= '0;
            pend <= 1'b1;
`ifdef SDRAM_PINGPONG_EN
            bank <= 1'b0;
`endif
        end else if (upd) begin
            if (pend || load) begin
                addr <= start_addr;
                pend <= 1'b0;
            end else if (wrap) begin
                addr <= start_addr;
`ifdef SDRAM_PINGPONG_EN
                // Writers flip to the other frame; readers follow the last completed write frame.
                bank <= (dir == DIR_WR) ? ~bank : wr_bank_done;
`endif
            end else begin
                addr <= next[ADDR_W-1:0];
            end
        end else if (granted) begin
            if (load) begin
                pend <= 1'b1;
            end
        end else if (load || (pick && pend)) begin
            addr <= start_addr;
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_nport_arbiter.sv
// Round-robin N-channel burst arbiter/address generator in front of the SDRAM core; grant+req one cycle
// after a request in IDLE, held until ack falls. Optional frame ping-pong banking via SDRAM_PINGPONG_EN.
module sdram_nport_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 22,
    parameter int LEN_W  = 9
) (
    input  logic                       clk_ref,
    input  logic                       rst,
    input  logic                       sdram_init_done,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH-1:0]          ch_dir,
    input  logic [NUM_CH*LEN_W-1:0]    ch_len,
    input  logic [NUM_CH-1:0]          ch_load,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_start_addr,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_max_addr,
    output logic [NUM_CH-1:0]          ch_grant,
    output logic [NUM_CH-1:0]          ch_frame_done,
    output logic                       sdram_wr_req,
    output logic                       sdram_rd_req,
    input  logic                       sdram_wr_ack,
    input  logic                       sdram_rd_ack,
    output logic [ADDR_W-1:0]          sdram_wraddr,
    output logic [ADDR_W-1:0]          sdram_rdaddr,
    output logic [LEN_W-1:0]           sdram_wr_len,
    output logic [LEN_W-1:0]           sdram_rd_len,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_CH);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  last_grant_q;
    logic [IDX_W-1:0]  grant_idx_q;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  cand;
    logic              sel_vld;
    logic              sel_dir;
    logic [LEN_W-1:0]  sel_len;
    logic [ADDR_W-1:0] sel_addr;
    logic              take;
    logic              dir_q;
    logic              ack_m;
    logic [ADDR_W-1:0] eff_addr [NUM_CH];

`ifdef SDRAM_PINGPONG_EN
    logic              wr_bank_done;
    logic [NUM_CH-1:0] done_bank;
`endif

    // Acks for the other direction are ignored.
    assign ack_m = (dir_q == DIR_WR) ? sdram_wr_ack : sdram_rd_ack;
    assign busy  = (state_q != ST_IDLE);

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = IDX_W'((int'(last_grant_q) + k) % NUM_CH);
            if (!sel_vld && ch_req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign sel_dir  = ch_dir[sel_idx];
    assign sel_len  = LEN_W'(ch_field(FLAT_W'(ch_len), int'(sel_idx), LEN_W));
    assign sel_addr = eff_addr[sel_idx];

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sdram_init_done && sel_vld) begin
                    take    = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ:  if (ack_m)  state_d = ST_XFER;
            ST_XFER: if (!ack_m) state_d = ST_UPD;
            ST_UPD:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_CH - 1);
            grant_idx_q  <= '0;
            dir_q        <= DIR_RD;
            ch_grant     <= '0;
            sdram_wr_req <= 1'b0;
            sdram_rd_req <= 1'b0;
            sdram_wraddr <= '0;
            sdram_rdaddr <= '0;
            sdram_wr_len <= '0;
            sdram_rd_len <= '0;
`ifdef SDRAM_PINGPONG_EN
            wr_bank_done <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (take) begin
                grant_idx_q <= sel_idx;
                dir_q       <= sel_dir;
                ch_grant    <= NUM_CH'(1) << sel_idx;
                if (sel_dir == DIR_WR) begin
                    sdram_wr_req <= 1'b1;
                    sdram_wraddr <= sel_addr;
                    sdram_wr_len <= sel_len;
                end else begin
                    sdram_rd_req <= 1'b1;
                    sdram_rdaddr <= sel_addr;
                    sdram_rd_len <= sel_len;
                end
            end
            if (state_q == ST_REQ && ack_m) begin
                sdram_wr_req <= 1'b0;
                sdram_rd_req <= 1'b0;
            end
            if (state_q == ST_UPD) begin
                last_grant_q <= grant_idx_q;
                ch_grant     <= '0;
`ifdef SDRAM_PINGPONG_EN
                if (dir_q == DIR_WR && ch_frame_done[grant_idx_q]) begin
                    wr_bank_done <= done_bank[grant_idx_q];
                end
`endif
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sdram_ch_addr_gen #(
            .ADDR_W(ADDR_W),
            .LEN_W (LEN_W)
        ) u_addr_gen (
            .clk_ref     (clk_ref),
            .rst         (rst),
            .load        (ch_load[i]),
            .pick        (take && (sel_idx == IDX_W'(i))),
            .granted     (ch_grant[i]),
            .upd         ((state_q == ST_UPD) && (grant_idx_q == IDX_W'(i))),
            .len         (LEN_W'(ch_field(FLAT_W'(ch_len), i, LEN_W))),
            .start_addr  (ADDR_W'(ch_field(FLAT_W'(ch_start_addr), i, ADDR_W))),
            .max_addr    (ADDR_W'(ch_field(FLAT_W'(ch_max_addr), i, ADDR_W))),
`ifdef SDRAM_PINGPONG_EN
            .dir         (dir_q),
            .wr_bank_done(wr_bank_done),
            .done_bank   (done_bank[i]),
`endif
            .eff_addr    (eff_addr[i]),
            .frame_done  (ch_frame_done[i])
        );
    end

endmodule
